// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared SD SPI-mode constants, card FSM states and CRC7 helper
// Shared by the card responder and the host controller.
//   CMDx / ACMD41   : command index constants
//   R1_*            : bit positions inside the R1 response byte
//   CRC7_POLY       : x^7 + x^3 + 1 without the x^7 term
//   OCR_VWIN        : OCR bits 23..0 (voltage window 2.7-3.6 V)
//   crc7_byte()     : advance a CRC7 by one byte, MSB first
package sd_pkg;

  localparam logic [5:0] CMD0   = 6'd0;
  localparam logic [5:0] CMD8   = 6'd8;
  localparam logic [5:0] CMD55  = 6'd55;
  localparam logic [5:0] CMD58  = 6'd58;
  localparam logic [5:0] ACMD41 = 6'd41;

  localparam int R1_IDLE    = 0;
  localparam int R1_ILLEGAL = 2;
  localparam int R1_CRC_ERR = 3;

  localparam logic [6:0]  CRC7_POLY = 7'h09;
  localparam logic [23:0] OCR_VWIN  = 24'hFF8000;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_RECV,
    ST_EXEC,
    ST_GAP,
    ST_RESP
  } card_state_e;

  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ CRC7_POLY;
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// rtl/sd_crc7.sv - bytewise CRC7 accumulator
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart from zero; when en is also high, data is the first byte
//   en         : fold data into the running CRC
//   data       : byte in, MSB first
//   crc        : running CRC7
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'd0;
    end else if (clr) begin
      crc <= en ? crc7_byte(7'd0, data) : 7'd0;
    end else if (en) begin
      crc <= crc7_byte(crc, data);
    end
  end

endmodule

// File: rtl/sd_spi_card_responder.sv
// rtl/sd_spi_card_responder.sv - SPI-mode SD card model: frame rx, CRC7 check, init tracking, R1/R3/R7 tx
// Ports:
//   clk, rst_n             : system clock (>= 4x spi_clk), asynchronous active-low reset
//   spi_clk, cs, mosi      : host SPI pins (mode 0, cs active low), sampled via 2-FF syncs
//   miso                   : card data, 1 while cs high or nothing to send
//   cmd_valid              : one-cycle pulse per accepted command
//   cmd_index, cmd_arg     : last accepted command, held
//   initialized            : card has left the idle state
module sd_spi_card_responder
  import sd_pkg::*;
#(
  parameter int   NCR        = 1,
  parameter int   INIT_POLLS = 2,
  parameter logic CCS        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_clk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        initialized
);

  localparam logic [3:0] GAP_LAST = 4'(NCR - 1);
  localparam logic [7:0] POLL_MAX = 8'(INIT_POLLS);

  logic [1:0] sclk_ff, cs_ff, mosi_ff;
  logic       sclk_q;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_ff <= 2'b00;
      cs_ff   <= 2'b11;
      mosi_ff <= 2'b11;
      sclk_q  <= 1'b0;
    end else begin
      sclk_ff <= {sclk_ff[0], spi_clk};
      cs_ff   <= {cs_ff[0], cs};
      mosi_ff <= {mosi_ff[0], mosi};
      sclk_q  <= sclk_ff[1];
    end
  end

  assign sclk_s    = sclk_ff[1];
  assign cs_s      = cs_ff[1];
  assign mosi_s    = mosi_ff[1];
  assign sclk_rise = sclk_s & ~sclk_q & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_q & ~cs_s;

  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic       rx_done;
  logic [7:0] rx_byte;
  logic       tx_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 7'd0;
    end else if (cs_s) begin
      bit_cnt <= 3'd0;
    end else if (sclk_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sr   <= {rx_sr[5:0], mosi_s};
    end
  end

  assign rx_done = sclk_rise & (bit_cnt == 3'd7);
  assign rx_byte = {rx_sr, mosi_s};
  // bit_cnt wraps to 0 on the 8th rise, so the next fall is the byte boundary
  assign tx_load = sclk_fall & (bit_cnt == 3'd0);

  card_state_e state, state_nxt;
  logic [47:0] frame;
  logic [2:0]  byte_cnt;
  logic [3:0]  gap_cnt;
  logic [39:0] resp_sr;
  logic [2:0]  resp_left;
  logic [7:0]  tx_sr;
  logic        idle, app;
  logic [7:0]  polls;
  logic [6:0]  crc_val;
  logic        frame_ok;

  logic        frame_start, crc_clr, crc_en, exec;
  logic [7:0]  tx_next;

  assign frame_ok = frame[0] & (frame[47:46] == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (cs_s) begin
      state_nxt = ST_HUNT;
    end else begin
      case (state)
        ST_HUNT: if (frame_start) state_nxt = ST_RECV;
        ST_RECV: if (rx_done && byte_cnt == 3'd5) state_nxt = ST_EXEC;
        ST_EXEC: state_nxt = frame_ok ? ST_GAP : ST_HUNT;
        ST_GAP:  if (tx_load && gap_cnt == GAP_LAST) state_nxt = ST_RESP;
        ST_RESP: if (tx_load && resp_left == 3'd1) state_nxt = ST_HUNT;
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    frame_start = (state == ST_HUNT) && rx_done && (rx_byte[7:6] == 2'b01);
    crc_clr     = frame_start;
    // bytes 1..5 feed the CRC; byte 6 carries it
    crc_en      = frame_start || ((state == ST_RECV) && rx_done && (byte_cnt != 3'd5));
    exec        = (state == ST_EXEC) && !cs_s;
    tx_next     = (state == ST_RESP) ? resp_sr[39:32] : 8'hFF;
  end

  sd_crc7 u_crc7 (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (rx_byte),
    .crc  (crc_val)
  );

  logic [5:0]  dec_idx;
  logic [31:0] dec_arg;
  logic        crc_bad, illegal, accept;
  logic        idle_nxt, app_nxt;
  logic [7:0]  polls_nxt;
  logic [7:0]  r1;
  logic [39:0] resp_nxt;
  logic [2:0]  len_nxt;

  always_comb begin
    dec_idx   = frame[45:40];
    dec_arg   = frame[39:8];
    crc_bad   = ((dec_idx == CMD0) || (dec_idx == CMD8)) && (frame[7:1] != crc_val);
    illegal   = 1'b0;
    accept    = 1'b1;
    idle_nxt  = idle;
    polls_nxt = polls;
    app_nxt   = 1'b0;
    r1        = 8'h00;
    resp_nxt  = 40'hFF_FFFF_FFFF;
    len_nxt   = 3'd1;
    if (crc_bad) begin
      // rejected frame: card state is left exactly as it was
      accept            = 1'b0;
      app_nxt           = app;
      r1[R1_IDLE]       = idle;
      r1[R1_CRC_ERR]    = 1'b1;
      resp_nxt[39:32]   = r1;
    end else begin
      case (dec_idx)
        CMD0: begin
          idle_nxt  = 1'b1;
          polls_nxt = 8'd0;
        end
        CMD55: app_nxt = 1'b1;
        ACMD41: begin
          if (app) begin
            if (polls < POLL_MAX) polls_nxt = polls + 8'd1;
            if (polls_nxt == POLL_MAX) idle_nxt = 1'b0;
          end else begin
            illegal = 1'b1;
          end
        end
        CMD8, CMD58: ;
        default: illegal = 1'b1;
      endcase
      r1[R1_IDLE]    = idle_nxt;
      r1[R1_ILLEGAL] = illegal;
      resp_nxt[39:32] = r1;
      if (dec_idx == CMD8) begin
        resp_nxt = {r1, 16'h0000, 4'h0, dec_arg[11:8], dec_arg[7:0]};
        len_nxt  = 3'd5;
      end else if (dec_idx == CMD58) begin
        resp_nxt = {r1, ~idle, CCS, 6'h00, OCR_VWIN};
        len_nxt  = 3'd5;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame     <= 48'd0;
      byte_cnt  <= 3'd0;
      gap_cnt   <= 4'd0;
      resp_sr   <= 40'hFF_FFFF_FFFF;
      resp_left <= 3'd0;
      tx_sr     <= 8'hFF;
      idle      <= 1'b1;
      app       <= 1'b0;
      polls     <= 8'd0;
      cmd_valid <= 1'b0;
      cmd_index <= 6'd0;
      cmd_arg   <= 32'd0;
    end else begin
      cmd_valid <= 1'b0;

      if (rx_done && (state == ST_HUNT || state == ST_RECV)) frame <= {frame[39:0], rx_byte};

      if (frame_start)                       byte_cnt <= 3'd1;
      else if (state == ST_RECV && rx_done)  byte_cnt <= byte_cnt + 3'd1;

      if (cs_s)           tx_sr <= 8'hFF;
      else if (tx_load)   tx_sr <= tx_next;
      else if (sclk_fall) tx_sr <= {tx_sr[6:0], 1'b1};

      if (state == ST_GAP && tx_load) gap_cnt <= gap_cnt + 4'd1;

      if (state == ST_RESP && tx_load) begin
        resp_sr   <= {resp_sr[31:0], 8'hFF};
        resp_left <= resp_left - 3'd1;
      end

      if (exec && frame_ok) begin
        idle      <= idle_nxt;
        polls     <= polls_nxt;
        app       <= app_nxt;
        resp_sr   <= resp_nxt;
        resp_left <= len_nxt;
        gap_cnt   <= 4'd0;
        if (accept) begin
          cmd_valid <= 1'b1;
          cmd_index <= dec_idx;
          cmd_arg   <= dec_arg;
        end
      end
    end
  end

  assign miso        = (cs | cs_s) ? 1'b1 : tx_sr[7];
  assign initialized = ~idle;

endmodule
